alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single combinational 32-bit ALU between two requesters, e.g. an execute pipe and a branch/address unit.
- Each requester presents an op code and two operands over a valid/ready handshake. The block grants one requester round-robin, drives the ALU from registers, captures the result and returns it on that requester's response channel.
- Only one operation is in flight at a time.

Parameters:
- WIDTH, 32, operand/result width.
- CTRL_W, 3, ALU op-code width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an op.
- req0_ready  out  1  requester 0 op accepted this cycle when valid&ready.
- req0_ctrl  in  CTRL_W  op code: 000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT.
- req0_a, req0_b  in  WIDTH  operands.
- resp0_valid  out  1  result for requester 0 available.
- resp0_ready  in  1  requester 0 consumes the result.
- resp0_data  out  WIDTH  result.
- resp0_err  out  1  op code was illegal (100, 110, 111).
- req1_*, resp1_*  same as the requester 0 ports, for requester 1.
- alu_ctrl  out  CTRL_W  to the ALU ctrl input, registered.
- alu_a, alu_b  out  WIDTH  to the ALU operand inputs, registered.
- alu_result  in  WIDTH  from the ALU, combinational, valid in the same cycle as its inputs.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- State machine has three states:
  - IDLE: no op in flight.
  - EXEC: ALU inputs registered; result captured at the end of this cycle.
  - RESP: response held until the owning requester accepts it.
- Reset (asynchronous, any state):
  - State goes to IDLE; last_grant is set to 1, so requester 0 wins the first tie.
  - alu_ctrl, alu_a, alu_b, resp*_data and resp*_err are set to 0.
  - resp*_valid and busy are set to 0.
  - req*_ready is forced to 0 while rst is high.
  - An in-flight op is discarded; no response is produced for it.
- Grant (IDLE only, combinational from req*_valid and last_grant):
  - If one requester is valid, it is granted.
  - If both are valid, the requester other than last_grant is granted.
  - reqN_ready equals (state==IDLE && granted==N); at most one ready is high per cycle.
  - req*_ready is 0 in EXEC and RESP.
- Accept edge (handshake completes):
  - Register the granted requester's ctrl/a/b into alu_ctrl/alu_a/alu_b.
  - Record owner and update last_grant to owner.
  - Move to EXEC.
- EXEC, one cycle:
  - Capture alu_result into the owner's resp_data.
  - If alu_ctrl is illegal, capture 0 and set resp_err=1; otherwise set resp_err=0.
  - Move to RESP.
- RESP:
  - Owner's resp_valid=1; the other requester's resp_valid stays 0.
  - resp_data and resp_err are held stable until respN_ready=1.
  - On the respN_ready edge: drop resp_valid and return to IDLE.
  - No new grant is made in the same cycle as the response handshake; next grant is possible in the following cycle.
- Latency: accept in cycle N, resp_valid high from cycle N+2. Minimum issue interval is 3 cycles with resp_ready tied high.
- alu_* outputs hold their last values in IDLE and RESP; they change only on an accept edge.
- Requester side rules:
  - A requester must hold valid/ctrl/a/b stable until ready.
  - A requester may drop valid before ready; the block does not latch un-accepted requests.
- Fairness: requesters that are continuously valid alternate 0,1,0,1.
- Width rule: results are WIDTH bits exactly. No sign or overflow handling in this block; the ALU defines arithmetic.

Test Plan:
- Reset, then req0 ADD a=5 b=7 with resp0_ready=1:
  - req0_ready=1 in cycle 0.
  - alu_ctrl=000, alu_a=5, alu_b=7 in cycle 1.
  - resp0_valid=1, resp0_data=12, resp0_err=0 in cycle 2.
  - resp1_valid stays 0 throughout.
- Both requesters continuously valid (req0 SUB 10-3, req1 AND 0xF0&0x3C), resp ready high:
  - Grants go 0,1,0,1.
  - resp0_data=7 and resp1_data=0x30 alternate.
  - Exactly one req*_ready per IDLE cycle.
- Backpressure: req1 OR 0x1|0x2 with resp1_ready=0 for 5 cycles:
  - resp1_valid=1 and resp1_data=3 held stable for all 5 cycles.
  - req0_ready stays 0 until the cycle after resp1_ready=1.
- Illegal op: req0_ctrl=110:
  - resp0_valid=1, resp0_err=1, resp0_data=0.
  - Next legal op returns resp0_err=0.
- Reset mid-operation: assert rst asynchronously during EXEC and again during RESP:
  - Outputs go to reset values immediately, with no clock edge needed.
  - No response appears after rst is released.
  - After release, a tie grants requester 0 first.
- Withdrawn request: req1_valid pulses for 1 cycle while the block is in RESP:
  - Request is not accepted.
  - No response is produced for requester 1.
  - busy returns to 0 after the resp0 handshake.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two
// valid/ready requesters; one operation in flight, result returned per requester.
module alu_arbiter #(
   parameter int WIDTH  = 32,
   parameter int CTRL_W = 3
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [CTRL_W-1:0] req0_ctrl,
   input  logic [WIDTH-1:0]  req0_a,
   input  logic [WIDTH-1:0]  req0_b,
   output logic              resp0_valid,
   input  logic              resp0_ready,
   output logic [WIDTH-1:0]  resp0_data,
   output logic              resp0_err,

   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [CTRL_W-1:0] req1_ctrl,
   input  logic [WIDTH-1:0]  req1_a,
   input  logic [WIDTH-1:0]  req1_b,
   output logic              resp1_valid,
   input  logic              resp1_ready,
   output logic [WIDTH-1:0]  resp1_data,
   output logic              resp1_err,

   output logic [CTRL_W-1:0] alu_ctrl,
   output logic [WIDTH-1:0]  alu_a,
   output logic [WIDTH-1:0]  alu_b,
   input  logic [WIDTH-1:0]  alu_result,
   output logic              busy
);

   localparam logic [CTRL_W-1:0] OP_ADD = CTRL_W'(0);
   localparam logic [CTRL_W-1:0] OP_SUB = CTRL_W'(1);
   localparam logic [CTRL_W-1:0] OP_AND = CTRL_W'(2);
   localparam logic [CTRL_W-1:0] OP_OR  = CTRL_W'(3);
   localparam logic [CTRL_W-1:0] OP_SLT = CTRL_W'(5);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_stateNext;
   logic              r_lastGrant;
   logic              r_owner;
   logic [CTRL_W-1:0] r_aluCtrl;
   logic [WIDTH-1:0]  r_aluA;
   logic [WIDTH-1:0]  r_aluB;
   logic [1:0]        r_respValid;
   logic [1:0]        r_respErr;
   logic [WIDTH-1:0]  r_respData [2];

   logic              w_grant0;
   logic              w_grant1;
   logic              w_accept;
   logic              w_ownerReady;
   logic              w_ctrlLegal;

   // A tie goes to whichever requester was not granted last.
   assign w_grant0     = (r_state == IDLE) && req0_valid && (!req1_valid || r_lastGrant);
   assign w_grant1     = (r_state == IDLE) && req1_valid && (!req0_valid || !r_lastGrant);
   assign w_accept     = w_grant0 || w_grant1;
   assign w_ownerReady = r_owner ? resp1_ready : resp0_ready;
   assign w_ctrlLegal  = r_aluCtrl inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_stateNext = EXEC;
         EXEC:    w_stateNext = RESP;
         RESP:    if (w_ownerReady) w_stateNext = IDLE;
         default: w_stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lastGrant    <= 1'b1;
         r_owner        <= 1'b0;
         r_aluCtrl      <= '0;
         r_aluA         <= '0;
         r_aluB         <= '0;
         r_respValid    <= '0;
         r_respErr      <= '0;
         r_respData[0]  <= '0;
         r_respData[1]  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_aluCtrl   <= w_grant1 ? req1_ctrl : req0_ctrl;
                  r_aluA      <= w_grant1 ? req1_a    : req0_a;
                  r_aluB      <= w_grant1 ? req1_b    : req0_b;
                  r_owner     <= w_grant1;
                  r_lastGrant <= w_grant1;
               end
            end
            EXEC: begin
               // Illegal op codes return zero regardless of what the ALU produced.
               r_respData[r_owner]  <= w_ctrlLegal ? alu_result : '0;
               r_respErr[r_owner]   <= !w_ctrlLegal;
               r_respValid[r_owner] <= 1'b1;
            end
            RESP: begin
               if (w_ownerReady) begin
                  r_respValid[r_owner] <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign req0_ready  = w_grant0 && !rst;
   assign req1_ready  = w_grant1 && !rst;
   assign resp0_valid = r_respValid[0];
   assign resp1_valid = r_respValid[1];
   assign resp0_data  = r_respData[0];
   assign resp1_data  = r_respData[1];
   assign resp0_err   = r_respErr[0];
   assign resp1_err   = r_respErr[1];
   assign alu_ctrl    = r_aluCtrl;
   assign alu_a       = r_aluA;
   assign alu_b       = r_aluB;
   assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU; every scenario task
// drives its own vectors and compares against hand-computed values.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [2:0]  req0_ctrl = '0, req1_ctrl = '0;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic        resp0_valid, resp1_valid;
   logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
   logic [31:0] resp0_data, resp1_data;
   logic        resp0_err, resp1_err;
   logic [2:0]  alu_ctrl;
   logic [31:0] alu_a, alu_b, alu_result;
   logic        busy;

   int total = 0;
   int bad   = 0;

   alu_arbiter #(.WIDTH(32), .CTRL_W(3)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
      .req0_a(req0_a), .req0_b(req0_b),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
      .resp0_data(resp0_data), .resp0_err(resp0_err),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
      .req1_a(req1_a), .req1_b(req1_b),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
      .resp1_data(resp1_data), .resp1_err(resp1_err),
      .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .busy(busy)
   );

   always #5 clk = ~clk;

   // External ALU stand-in; illegal codes yield a marker value that must never surface.
   always_comb begin
      alu_result = 32'hDEADBEEF;
      case (alu_ctrl)
         3'b000: alu_result = alu_a + alu_b;
         3'b001: alu_result = alu_a - alu_b;
         3'b010: alu_result = alu_a & alu_b;
         3'b011: alu_result = alu_a | alu_b;
         3'b101: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
         default: alu_result = 32'hDEADBEEF;
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic pulseReset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      req0_valid = 1'b1;
      #1;
      if (req0_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_ready0: got %0b want 0", req0_ready); end total++;
      if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy: got %0b want 0", busy); end total++;
      if ({resp0_valid, resp1_valid} !== 2'b00) begin bad++; $display("[TB] FAIL rst_rvalid: got %b want 00", {resp0_valid, resp1_valid}); end total++;
      if ({alu_ctrl, alu_a, alu_b} !== 67'd0) begin bad++; $display("[TB] FAIL rst_alu: got %h want 0", {alu_ctrl, alu_a, alu_b}); end total++;
      if ({resp0_data, resp1_data, resp0_err, resp1_err} !== 66'd0) begin bad++; $display("[TB] FAIL rst_resp: got %h want 0", {resp0_data, resp1_data, resp0_err, resp1_err}); end total++;
      req0_valid = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_single_add();
      tick();
      req0_valid = 1'b1; req0_ctrl = 3'b000; req0_a = 32'd5; req0_b = 32'd7; resp0_ready = 1'b1;
      #1;
      if (req0_ready !== 1'b1) begin bad++; $display("[TB] FAIL add_ready0: got %0b want 1", req0_ready); end total++;
      if (req1_ready !== 1'b0) begin bad++; $display("[TB] FAIL add_ready1: got %0b want 0", req1_ready); end total++;
      tick();
      req0_valid = 1'b0;
      #1;
      if ({alu_ctrl, alu_a, alu_b} !== {3'b000, 32'd5, 32'd7}) begin bad++; $display("[TB] FAIL add_alu: got %0d/%0d/%0d want 0/5/7", alu_ctrl, alu_a, alu_b); end total++;
      if (busy !== 1'b1) begin bad++; $display("[TB] FAIL add_busy: got %0b want 1", busy); end total++;
      if (resp0_valid !== 1'b0) begin bad++; $display("[TB] FAIL add_early: got %0b want 0", resp0_valid); end total++;
      tick();
      #1;
      if ({resp0_valid, resp0_err} !== 2'b10) begin bad++; $display("[TB] FAIL add_rvalid: got v=%0b e=%0b want v=1 e=0", resp0_valid, resp0_err); end total++;
      if (resp0_data !== 32'd12) begin bad++; $display("[TB] FAIL add_data: got %0d want 12", resp0_data); end total++;
      if (resp1_valid !== 1'b0) begin bad++; $display("[TB] FAIL add_r1: got %0b want 0", resp1_valid); end total++;
      tick();
      #1;
      if ({resp0_valid, busy, resp1_valid} !== 3'b000) begin bad++; $display("[TB] FAIL add_done: got %b want 000", {resp0_valid, busy, resp1_valid}); end total++;
   endtask

   task automatic test_fairness();
      int exp;
      pulseReset();
      req0_ctrl = 3'b001; req0_a = 32'd10;   req0_b = 32'd3;
      req1_ctrl = 3'b010; req1_a = 32'hF0;   req1_b = 32'h3C;
      req0_valid = 1'b1; req1_valid = 1'b1; resp0_ready = 1'b1; resp1_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp = k % 2;
         #1;
         if ({req0_ready, req1_ready} !== ((exp == 0) ? 2'b10 : 2'b01)) begin bad++; $display("[TB] FAIL fair_grant%0d: got %b want owner %0d", k, {req0_ready, req1_ready}, exp); end total++;
         tick();
         tick();
         #1;
         if (exp == 0) begin
            if ({resp0_valid, resp1_valid} !== 2'b10 || resp0_data !== 32'd7) begin bad++; $display("[TB] FAIL fair_resp%0d: got v=%b d=%h want 10/7", k, {resp0_valid, resp1_valid}, resp0_data); end total++;
         end else begin
            if ({resp0_valid, resp1_valid} !== 2'b01 || resp1_data !== 32'h30) begin bad++; $display("[TB] FAIL fair_resp%0d: got v=%b d=%h want 01/30", k, {resp0_valid, resp1_valid}, resp1_data); end total++;
         end
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      req1_ctrl = 3'b011; req1_a = 32'h1; req1_b = 32'h2; req1_valid = 1'b1; resp1_ready = 1'b0;
      #1;
      if (req1_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_accept: got %0b want 1", req1_ready); end total++;
      tick();
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_ctrl = 3'b000; req0_a = 32'd20; req0_b = 32'd22; resp0_ready = 1'b1;
      #1;
      if (req0_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_exec_ready0: got %0b want 0", req0_ready); end total++;
      tick();
      for (int i = 0; i < 5; i++) begin
         #1;
         if ({resp1_valid, req0_ready} !== 2'b10 || resp1_data !== 32'd3) begin bad++; $display("[TB] FAIL bp_hold%0d: got v/r=%b d=%0d want 10/3", i, {resp1_valid, req0_ready}, resp1_data); end total++;
         tick();
      end
      resp1_ready = 1'b1;
      #1;
      if (req0_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_hs_ready0: got %0b want 0", req0_ready); end total++;
      tick();
      #1;
      if ({req0_ready, resp1_valid} !== 2'b10) begin bad++; $display("[TB] FAIL bp_after: got %b want 10", {req0_ready, resp1_valid}); end total++;
      tick();
      req0_valid = 1'b0;
      tick();
      #1;
      if (resp0_valid !== 1'b1 || resp0_data !== 32'd42) begin bad++; $display("[TB] FAIL bp_next: got v=%0b d=%0d want 1/42", resp0_valid, resp0_data); end total++;
      tick();
   endtask

   task automatic test_illegal();
      req0_valid = 1'b1; req0_ctrl = 3'b110; req0_a = 32'd9; req0_b = 32'd4; resp0_ready = 1'b1;
      tick();
      req0_valid = 1'b0;
      tick();
      #1;
      if ({resp0_valid, resp0_err} !== 2'b11 || resp0_data !== 32'd0) begin bad++; $display("[TB] FAIL ill_resp: got v=%0b e=%0b d=%h want 1/1/0", resp0_valid, resp0_err, resp0_data); end total++;
      tick();
      req0_valid = 1'b1; req0_ctrl = 3'b010; req0_a = 32'hFF; req0_b = 32'h0F;
      tick();
      req0_valid = 1'b0;
      tick();
      #1;
      if ({resp0_valid, resp0_err} !== 2'b10 || resp0_data !== 32'h0F) begin bad++; $display("[TB] FAIL ill_recover: got v=%0b e=%0b d=%h want 1/0/f", resp0_valid, resp0_err, resp0_data); end total++;
      tick();
   endtask

   task automatic test_reset_mid();
      req0_valid = 1'b1; req0_ctrl = 3'b001; req0_a = 32'd5; req0_b = 32'd2; resp0_ready = 1'b0;
      tick();
      req0_valid = 1'b0;
      #1;
      if (busy !== 1'b1 || alu_a !== 32'd5) begin bad++; $display("[TB] FAIL rm_exec_pre: got busy=%0b a=%0d want 1/5", busy, alu_a); end total++;
      rst = 1'b1;
      #1;
      if ({busy, alu_ctrl, alu_a, alu_b} !== 68'd0) begin bad++; $display("[TB] FAIL rm_exec_async: got %h want 0", {busy, alu_ctrl, alu_a, alu_b}); end total++;
      tick();
      rst = 1'b0;
      tick();
      tick();
      #1;
      if ({resp0_valid, resp1_valid, busy} !== 3'b000) begin bad++; $display("[TB] FAIL rm_exec_noresp: got %b want 000", {resp0_valid, resp1_valid, busy}); end total++;
      req0_valid = 1'b1;
      tick();
      req0_valid = 1'b0;
      tick();
      #1;
      if (resp0_valid !== 1'b1 || resp0_data !== 32'd3) begin bad++; $display("[TB] FAIL rm_resp_pre: got v=%0b d=%0d want 1/3", resp0_valid, resp0_data); end total++;
      rst = 1'b1;
      #1;
      if ({resp0_valid, resp0_err, busy} !== 3'b000 || resp0_data !== 32'd0) begin bad++; $display("[TB] FAIL rm_resp_async: got v/e/b=%b d=%0d want 000/0", {resp0_valid, resp0_err, busy}, resp0_data); end total++;
      tick();
      rst = 1'b0;
      tick();
      tick();
      #1;
      if ({resp0_valid, resp1_valid, busy} !== 3'b000) begin bad++; $display("[TB] FAIL rm_resp_noresp: got %b want 000", {resp0_valid, resp1_valid, busy}); end total++;
      req0_valid = 1'b1; req1_valid = 1'b1; req1_ctrl = 3'b011; req1_a = 32'h1; req1_b = 32'h2;
      #1;
      if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("[TB] FAIL rm_tie: got %b want 10", {req0_ready, req1_ready}); end total++;
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0; resp0_ready = 1'b1;
      tick();
      #1;
      if (resp0_valid !== 1'b1 || resp0_data !== 32'd3) begin bad++; $display("[TB] FAIL rm_tie_resp: got v=%0b d=%0d want 1/3", resp0_valid, resp0_data); end total++;
      tick();
   endtask

   task automatic test_withdrawn();
      req0_valid = 1'b1; req0_ctrl = 3'b011; req0_a = 32'd4; req0_b = 32'd8; resp0_ready = 1'b0;
      tick();
      req0_valid = 1'b0;
      tick();
      req1_valid = 1'b1; req1_ctrl = 3'b000; req1_a = 32'd100; req1_b = 32'd1;
      #1;
      if (req1_ready !== 1'b0) begin bad++; $display("[TB] FAIL wd_ready1: got %0b want 0", req1_ready); end total++;
      tick();
      req1_valid = 1'b0;
      #1;
      if ({resp0_valid, resp1_valid, busy} !== 3'b101 || resp0_data !== 32'd12) begin bad++; $display("[TB] FAIL wd_resp: got v/v/b=%b d=%0d want 101/12", {resp0_valid, resp1_valid, busy}, resp0_data); end total++;
      resp0_ready = 1'b1;
      tick();
      #1;
      if ({busy, resp0_valid} !== 2'b00) begin bad++; $display("[TB] FAIL wd_idle: got %b want 00", {busy, resp0_valid}); end total++;
      tick();
      tick();
      #1;
      if ({resp1_valid, busy} !== 2'b00) begin bad++; $display("[TB] FAIL wd_nothing: got %b want 00", {resp1_valid, busy}); end total++;
   endtask

   // Watchdog so a stuck run still ends with a reported failure.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      #3;
      test_reset();
      test_single_add();
      test_fairness();
      test_backpressure();
      test_illegal();
      test_reset_mid();
      test_withdrawn();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
